fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 78 +++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, FIFO geometry, FSM state encoding and queue entry layout
// for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int PC_W       = 12;
  localparam int INSTR_W    = 19;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;   // holds occupancy 0..FIFO_DEPTH

  // IDLE: no request outstanding; BUSY: live request; SQUASH: request
  // outstanding whose data will be thrown away after a flush.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus1;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue of fetched {instruction, PC+1} pairs.
// Slot 0 is always the head; a pop shifts slot 1 down. clear wins over
// push and pop. The head reads as all-zero while the queue is empty.
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fq_entry_t        push_data,
  output fq_entry_t        head,
  output logic [CNT_W-1:0] count
);

  fq_entry_t        slot0_q, slot0_d;
  fq_entry_t        slot1_q, slot1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next slot contents and occupancy from push/pop/clear.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    if (clear) begin
      slot0_d = '0;
      slot1_d = '0;
      cnt_d   = '0;
    end else begin
      case ({push, pop})
        2'b01: begin
          if (cnt_q != '0) begin
            slot0_d = slot1_q;
            slot1_d = '0;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        2'b10: begin
          if (cnt_q == '0) begin
            slot0_d = push_data;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == CNT_W'(1)) begin
            slot1_d = push_data;
            cnt_d   = CNT_W'(2);
          end
        end
        2'b11: begin
          if (cnt_q == CNT_W'(2)) begin
            slot0_d = slot1_q;
            slot1_d = push_data;
          end else begin
            slot0_d = push_data;
            cnt_d   = CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Queue storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head  = (cnt_q != '0) ? slot0_q : '0;
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, buffers up to
// two returned instructions, and presents the oldest one to IF/ID.
//
// Memory handshake: imemReq=1 with imemAddr is a request; it and the address
// hold until a cycle with imemReady=1, which completes it (imemReady in the
// first request cycle is a zero-wait completion). imemReady with imemReq=0
// is ignored. On the IF/ID side fetchValid is the valid and !stall is the
// ready; an entry leaves the queue at an edge where both are high.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    branchTarget,
  input  logic               imemReady,
  input  logic [INSTR_W-1:0] imemData,
  output logic               imemReq,
  output logic [PC_W-1:0]    imemAddr,
  output logic               fetchValid,
  output logic [PC_W-1:0]    PCPlus1Out,
  output logic [INSTR_W-1:0] instructionOut
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  req_addr_q, req_addr_d;
  logic [PC_W-1:0]  req_addr_inc;
  logic             push, pop, can_issue;
  logic [CNT_W:0]   occ_next;
  logic [CNT_W-1:0] count;
  fq_entry_t        push_data, head;

  assign req_addr_inc       = req_addr_q + PC_W'(1);
  assign push               = (state_q == ST_BUSY) && imemReady && !flush;
  assign fetchValid         = (count != '0) && !flush;
  assign pop                = fetchValid && !stall;
  assign push_data.instr    = imemData;
  assign push_data.pc_plus1 = req_addr_inc;

  // Occupancy after this edge decides whether a new request may start, so a
  // completing request always finds a free slot.
  always_comb begin
    occ_next  = {1'b0, count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
    can_issue = !flush && (occ_next <= (CNT_W+1)'(1));
  end

  // Next-state, PC and request-address logic; flush redirects PC last so it
  // overrides the sequential update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (can_issue) begin
          state_d    = ST_BUSY;
          req_addr_d = pc_q;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = imemReady ? ST_IDLE : ST_SQUASH;
        end else if (imemReady) begin
          pc_d = req_addr_inc;
          if (can_issue) begin
            state_d    = ST_BUSY;
            req_addr_d = req_addr_inc;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SQUASH: begin
        if (imemReady) begin
          if (can_issue) begin
            state_d    = ST_BUSY;
            req_addr_d = pc_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) pc_d = branchTarget;
  end

  // FSM state, PC and request address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  fetch_queue u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clear    (flush),
    .push_data(push_data),
    .head     (head),
    .count    (count)
  );

  assign imemReq        = (state_q != ST_IDLE);
  assign imemAddr       = req_addr_q;
  assign PCPlus1Out     = head.pc_plus1;
  assign instructionOut = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized stall,
// flush and memory wait states, all checked against a transaction-level
// model (expected address stream plus a queue of expected PC+1 values).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush, imemReady;
  logic [11:0] branchTarget, imemAddr, PCPlus1Out;
  logic [18:0] imemData, instructionOut;
  logic        imemReq, fetchValid;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branchTarget  (branchTarget),
    .imemReady     (imemReady),
    .imemData      (imemData),
    .imemReq       (imemReq),
    .imemAddr      (imemAddr),
    .fetchValid    (fetchValid),
    .PCPlus1Out    (PCPlus1Out),
    .instructionOut(instructionOut)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [11:0] exp_q[$];     // expected PC+1 of each entry held by the fetch unit
  logic [11:0] req_exp;      // address the next useful request must carry
  logic        squashed;     // outstanding request was flushed
  logic        pend;         // request outstanding and not completed last cycle
  logic [11:0] pend_addr;
  int          mem_cnt, mem_waits, pop_cnt;
  logic        rand_waits, data_hash;
  logic        last_pop;
  logic [11:0] last_pc1;

  function automatic logic [18:0] mem_word(input logic [11:0] a);
    if (data_hash) return {~a[6:0], a};
    return {7'h00, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    req_exp  = 12'h000;
    squashed = 1'b0;
    pend     = 1'b0;
    mem_cnt  = 0;
  endtask

  // One cycle: drive memory response and control inputs just after the
  // falling edge, check outputs against the model, advance the model.
  task automatic step(input logic st, input logic fl, input logic [11:0] tgt);
    logic do_pop;
    if (imemReq) imemReady = (mem_cnt >= mem_waits);
    else imemReady = 1'($urandom_range(0, 1));
    imemData     = (imemReq && imemReady) ? mem_word(imemAddr) : 19'($urandom);
    stall        = st;
    flush        = fl;
    branchTarget = tgt;
    #1;
    if (pend) begin
      check("req_hold", imemReq, 1'b1);
      check("addr_hold", imemAddr, pend_addr);
    end
    if (exp_q.size() == 0) begin
      check("valid_empty", fetchValid, 1'b0);
      check("pc1_empty", PCPlus1Out, 12'h000);
      check("instr_empty", instructionOut, 19'h0);
    end else begin
      check("valid", fetchValid, !fl);
      check("head_pc1", PCPlus1Out, exp_q[0]);
      check("head_instr", instructionOut, mem_word(exp_q[0] - 12'd1));
    end
    do_pop   = (exp_q.size() != 0) && !fl && !st;
    last_pop = do_pop;
    last_pc1 = PCPlus1Out;
    if (do_pop) begin
      void'(exp_q.pop_front());
      pop_cnt++;
    end
    if (imemReq && imemReady) begin
      if (fl || squashed) begin
        squashed = 1'b0;
      end else begin
        check("req_addr", imemAddr, req_exp);
        exp_q.push_back(req_exp + 12'd1);
        req_exp = req_exp + 12'd1;
        check("no_overflow", exp_q.size() <= 2, 1'b1);
      end
    end
    if (fl) begin
      exp_q.delete();
      req_exp = tgt;
      if (imemReq && !imemReady) squashed = 1'b1;
    end
    pend      = imemReq && !imemReady;
    pend_addr = imemAddr;
    if (imemReq) begin
      if (imemReady) begin
        mem_cnt = 0;
        if (rand_waits) mem_waits = $urandom_range(0, 3);
      end else begin
        mem_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_valid;
    int          got;
    logic [11:0] held;
    logic [11:0] wrap_pc1[2];

    rst = 1'b1; stall = 1'b0; flush = 1'b0; branchTarget = '0;
    imemReady = 1'b0; imemData = '0;
    mem_waits = 0; rand_waits = 1'b0; data_hash = 1'b0; pop_cnt = 0;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_req", imemReq, 1'b0);
    check("rst_addr", imemAddr, 12'h000);
    check("rst_valid", fetchValid, 1'b0);
    check("rst_pc1", PCPlus1Out, 12'h000);
    check("rst_instr", instructionOut, 19'h0);
    rst = 1'b0;

    // zero-wait streaming after reset, imemData = address
    first_valid = -1;
    for (int c = 0; c < 12; c++) begin
      if (fetchValid && first_valid < 0) first_valid = c;
      step(1'b0, 1'b0, 12'h000);
    end
    check("first_valid_cycle", first_valid, 2);
    check("throughput", pop_cnt, 10);

    // stall 4 cycles while streaming
    held = exp_q[0];
    for (int c = 0; c < 4; c++) begin
      check("stall_head", PCPlus1Out, held);
      step(1'b1, 1'b0, 12'h000);
    end
    check("stall_full_valid", fetchValid, 1'b1);
    check("stall_req_drop", imemReq, 1'b0);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 12'h000);

    // 2 wait states, request at 0x005, flush to 0x100 during the wait
    step(1'b0, 1'b1, 12'h005);
    data_hash = 1'b1;
    mem_waits = 2;
    step(1'b0, 1'b0, 12'h000);
    check("w_req", imemReq, 1'b1);
    check("w_addr", imemAddr, 12'h005);
    step(1'b0, 1'b1, 12'h100);
    for (int c = 0; c < 2; c++) begin
      check("w_hold_addr", imemAddr, 12'h005);
      step(1'b0, 1'b0, 12'h000);
    end
    check("w_redirect_req", imemReq, 1'b1);
    check("w_redirect_addr", imemAddr, 12'h100);
    for (int c = 0; c < 10 && !fetchValid; c++) step(1'b0, 1'b0, 12'h000);
    check("w_first_valid", fetchValid, 1'b1);
    check("w_first_pc1", PCPlus1Out, 12'h101);
    mem_waits = 0;

    // flush and stall together with the queue full
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 12'h000);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 12'h000);
    check("fs_full_valid", fetchValid, 1'b1);
    step(1'b1, 1'b1, 12'h200);
    check("fs_empty_valid", fetchValid, 1'b0);
    check("fs_empty_pc1", PCPlus1Out, 12'h000);

    // branch to 0xFFF and stream across the wrap
    step(1'b0, 1'b1, 12'hFFF);
    wrap_pc1[0] = 12'hABC;
    wrap_pc1[1] = 12'hABC;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      step(1'b0, 1'b0, 12'h000);
      if (last_pop) begin
        wrap_pc1[got] = last_pc1;
        got++;
      end
    end
    check("wrap_pc1_0", wrap_pc1[0], 12'h000);
    check("wrap_pc1_1", wrap_pc1[1], 12'h001);

    // reset pulsed mid-request with entries buffered
    mem_waits = 3;
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 12'h000);
    for (int c = 0; c < 10 && !(imemReq && exp_q.size() != 0); c++) step(1'b1, 1'b0, 12'h000);
    check("mid_req_pending", imemReq, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_req", imemReq, 1'b0);
    check("async_addr", imemAddr, 12'h000);
    check("async_valid", fetchValid, 1'b0);
    check("async_pc1", PCPlus1Out, 12'h000);
    check("async_instr", instructionOut, 19'h0);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    model_reset();
    mem_waits = 0;
    step(1'b0, 1'b0, 12'h000);
    check("post_rst_req", imemReq, 1'b1);
    check("post_rst_addr", imemAddr, 12'h000);

    // randomized traffic
    rand_waits = 1'b1;
    pop_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [11:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(12'hFFC, 12'hFFF)) : 12'($urandom);
      step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0), tgt);
    end
    check("random_progress", pop_cnt > 200, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
